// File: rtl/tst_din_gen.sv
// tst_din_gen: test-pattern stream source.
// While test_en is high it emits back-to-back frames of FRAME_BEATS beats on an
// AXI4-Stream master. Each 32-bit lane carries {iteration[15:0], word_index[15:0]}.
// Completed frames are counted in itecnt, which clears only when a new run starts
// from IDLE and holds its value in IDLE so it can be read after the test stops.
//
// Stream handshake: a beat transfers on any cycle where M_AXIS_TVALID and
// M_AXIS_TREADY are both high. Once TVALID is raised, TDATA, TLAST and TVALID
// are held unchanged until that transfer. TVALID is a register, never a
// combinational function of TREADY, and it stays high for the whole frame.
module tst_din_gen #(
  parameter int TDATA_WIDTH = 128,
  parameter int FRAME_BEATS = 262144,
  parameter int BEAT_CNT_W  = 18
) (
  input  logic                   ACLK,
  input  logic                   ARESET,
  input  logic                   test_en,
  output logic [31:0]            itecnt,
  output logic                   busy,
  output logic [TDATA_WIDTH-1:0] M_AXIS_TDATA,
  output logic                   M_AXIS_TVALID,
  input  logic                   M_AXIS_TREADY,
  output logic                   M_AXIS_TLAST
);

  localparam int LANES = TDATA_WIDTH / 32;
  localparam logic [BEAT_CNT_W-1:0] LAST_BEAT = BEAT_CNT_W'(FRAME_BEATS - 1);

  // RUN: enabled and streaming. DRAIN: disabled, finishing the current frame.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                state;
  logic [BEAT_CNT_W-1:0] beat;
  logic [31:0]           itecnt_inc;
  logic                  xfer;
  logic                  last_xfer;

  // Builds one beat: lane i carries {ite, (k*LANES + i) mod 2^16}.
  function automatic logic [TDATA_WIDTH-1:0] pattern(input logic [15:0]           ite,
                                                     input logic [BEAT_CNT_W-1:0] k);
    logic [TDATA_WIDTH-1:0] d;
    logic [31:0]            base;
    d    = '0;
    base = 32'(k) * 32'(LANES);
    for (int i = 0; i < LANES; i++) begin
      d[32*i +: 32] = {ite, 16'(base + 32'(i))};
    end
    return d;
  endfunction

  // Transfer qualifiers and the count value the next frame will carry.
  assign xfer       = M_AXIS_TVALID & M_AXIS_TREADY;
  assign last_xfer  = xfer && (beat == LAST_BEAT);
  assign itecnt_inc = itecnt + 32'd1;
  assign busy       = (state != IDLE);

  // Frame sequencer: state, beat counter, iteration counter and the output beat register.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state         <= IDLE;
      beat          <= '0;
      itecnt        <= '0;
      M_AXIS_TVALID <= 1'b0;
      M_AXIS_TLAST  <= 1'b0;
      M_AXIS_TDATA  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (test_en) begin
            state         <= RUN;
            beat          <= '0;
            itecnt        <= '0;
            M_AXIS_TVALID <= 1'b1;
            M_AXIS_TLAST  <= 1'b0;
            M_AXIS_TDATA  <= pattern(16'd0, '0);
          end
        end
        RUN, DRAIN: begin
          // Enable only decides whether the frame ends in RUN or DRAIN; it never cuts a frame.
          state <= test_en ? RUN : DRAIN;
          if (last_xfer) begin
            itecnt <= itecnt_inc;
            beat   <= '0;
            if (test_en) begin
              state         <= RUN;
              M_AXIS_TVALID <= 1'b1;
              M_AXIS_TLAST  <= 1'b0;
              M_AXIS_TDATA  <= pattern(itecnt_inc[15:0], '0);
            end else begin
              state         <= IDLE;
              M_AXIS_TVALID <= 1'b0;
              M_AXIS_TLAST  <= 1'b0;
            end
          end else if (xfer) begin
            beat          <= beat + 1'b1;
            M_AXIS_TLAST  <= ((beat + 1'b1) == LAST_BEAT);
            M_AXIS_TDATA  <= pattern(itecnt[15:0], beat + 1'b1);
          end
        end
        default: begin
          state         <= IDLE;
          M_AXIS_TVALID <= 1'b0;
          M_AXIS_TLAST  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tst_din_gen.sv
// tb_tst_din_gen: directed bench for tst_din_gen with 8-beat frames, 128-bit data.
module tb_tst_din_gen;

  localparam int TW = 128;
  localparam int FB = 8;

  // Clock / reset / DUT signals
  logic          ACLK = 1'b0;
  logic          ARESET;
  logic          test_en;
  logic [31:0]   itecnt;
  logic          busy;
  logic [TW-1:0] M_AXIS_TDATA;
  logic          M_AXIS_TVALID;
  logic          M_AXIS_TREADY;
  logic          M_AXIS_TLAST;

  int n_cmp = 0;
  int n_err = 0;

  always #5 ACLK = ~ACLK;

  tst_din_gen #(
    .TDATA_WIDTH(TW),
    .FRAME_BEATS(FB),
    .BEAT_CNT_W (3)
  ) dut (
    .ACLK         (ACLK),
    .ARESET       (ARESET),
    .test_en      (test_en),
    .itecnt       (itecnt),
    .busy         (busy),
    .M_AXIS_TDATA (M_AXIS_TDATA),
    .M_AXIS_TVALID(M_AXIS_TVALID),
    .M_AXIS_TREADY(M_AXIS_TREADY),
    .M_AXIS_TLAST (M_AXIS_TLAST)
  );

  // Expected beat: lane i = {ite[15:0], k*4+i}
  function automatic logic [TW-1:0] exp_beat(input int ite, input int k);
    logic [TW-1:0] d;
    for (int i = 0; i < 4; i++) d[32*i +: 32] = {ite[15:0], 16'(k * 4 + i)};
    return d;
  endfunction

  task automatic check(input string tag, input logic [TW-1:0] obs, input logic [TW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(negedge ACLK);
  endtask

  // Checks one beat presented at the current falling edge (TREADY high), then advances.
  task automatic beat_step(input int ite, input int k);
    check("tvalid", TW'(M_AXIS_TVALID), TW'(1));
    check("busy", TW'(busy), TW'(1));
    check("tdata", M_AXIS_TDATA, exp_beat(ite, k));
    check("tlast", TW'(M_AXIS_TLAST), TW'(k == FB - 1));
    check("itecnt_frame", TW'(itecnt), TW'(ite));
    tick();
  endtask

  logic [15:0] stall_pat;
  int          k_s;
  int          ite_s;
  int          xfers;
  int          cyc;
  logic        rdy;

  initial begin
    // Reset block
    ARESET        = 1'b1;
    test_en       = 1'b0;
    M_AXIS_TREADY = 1'b1;
    tick();
    tick();
    check("rst_tvalid", TW'(M_AXIS_TVALID), TW'(0));
    check("rst_tlast", TW'(M_AXIS_TLAST), TW'(0));
    check("rst_busy", TW'(busy), TW'(0));
    check("rst_itecnt", TW'(itecnt), TW'(0));
    check("rst_tdata", M_AXIS_TDATA, TW'(0));
    ARESET = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    check("idle_tvalid", TW'(M_AXIS_TVALID), TW'(0));

    // 1: start, 1-cycle latency, first frame and seamless second frame
    test_en = 1'b1;
    tick();
    check("t1_first_beat", M_AXIS_TDATA, 128'h00000003_00000002_00000001_00000000);
    for (int k = 0; k < FB; k++) beat_step(0, k);
    check("t1_itecnt", TW'(itecnt), TW'(1));
    check("t1_f2_lane0", TW'(M_AXIS_TDATA[31:0]), TW'(32'h00010000));
    check("t1_f2_tvalid", TW'(M_AXIS_TVALID), TW'(1));
    for (int k = 0; k < FB; k++) beat_step(1, k);

    // 2: drop enable during beat 3 of frame 3; frame completes then IDLE
    for (int k = 0; k < FB; k++) begin
      if (k == 3) test_en = 1'b0;
      beat_step(2, k);
    end
    check("t2_itecnt", TW'(itecnt), TW'(3));
    check("t2_tvalid", TW'(M_AXIS_TVALID), TW'(0));
    check("t2_busy", TW'(busy), TW'(0));
    check("t2_tlast", TW'(M_AXIS_TLAST), TW'(0));
    for (int i = 0; i < 4; i++) tick();
    check("t2_itecnt_hold", TW'(itecnt), TW'(3));
    check("t2_tvalid_hold", TW'(M_AXIS_TVALID), TW'(0));

    // 4: re-enable clears itecnt on the start edge
    test_en = 1'b1;
    tick();
    check("t4_itecnt_clr", TW'(itecnt), TW'(0));
    check("t4_lane0", TW'(M_AXIS_TDATA[31:0]), TW'(32'h00000000));
    check("t4_tvalid", TW'(M_AXIS_TVALID), TW'(1));

    // 3: fixed stall pattern over 4 frames; beats must hold while stalled
    stall_pat = 16'b1011_0010_1101_0110;
    k_s = 0; ite_s = 0; xfers = 0; cyc = 0;
    while (xfers < 32 && cyc < 200) begin
      check("t3_tvalid", TW'(M_AXIS_TVALID), TW'(1));
      check("t3_tdata", M_AXIS_TDATA, exp_beat(ite_s, k_s));
      check("t3_tlast", TW'(M_AXIS_TLAST), TW'(k_s == FB - 1));
      rdy = stall_pat[cyc % 16];
      M_AXIS_TREADY = rdy;
      tick();
      cyc++;
      if (rdy) begin
        xfers++;
        k_s++;
        if (k_s == FB) begin
          k_s = 0;
          ite_s++;
        end
      end
    end
    check("t3_budget", TW'(xfers), TW'(32));
    check("t3_itecnt", TW'(itecnt), TW'(4));
    M_AXIS_TREADY = 1'b1;

    // 5: enable low for 2 cycles mid-frame, no clear and no gap
    for (int k = 0; k < FB; k++) begin
      if (k == 2) test_en = 1'b0;
      if (k == 4) test_en = 1'b1;
      beat_step(4, k);
    end
    check("t5_itecnt", TW'(itecnt), TW'(5));
    check("t5_lane0", TW'(M_AXIS_TDATA[31:0]), TW'(32'h00050000));
    check("t5_tvalid", TW'(M_AXIS_TVALID), TW'(1));

    // 6: asynchronous reset at beat 5
    for (int k = 0; k < 5; k++) beat_step(5, k);
    check("t6_pre_tdata", M_AXIS_TDATA, exp_beat(5, 5));
    #2 ARESET = 1'b1;
    #1;
    check("t6_rst_tvalid", TW'(M_AXIS_TVALID), TW'(0));
    check("t6_rst_tlast", TW'(M_AXIS_TLAST), TW'(0));
    check("t6_rst_busy", TW'(busy), TW'(0));
    check("t6_rst_itecnt", TW'(itecnt), TW'(0));
    tick();
    tick();
    ARESET = 1'b0;
    tick();
    check("t6_restart_lane0", TW'(M_AXIS_TDATA[31:0]), TW'(32'h00000000));
    check("t6_restart_tvalid", TW'(M_AXIS_TVALID), TW'(1));
    for (int k = 0; k < FB; k++) beat_step(0, k);
    check("t6_itecnt", TW'(itecnt), TW'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
